sequencer: RTL and testbench
============================

SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 SHALL take parameters CALL_DEPTH (default 32, call-stack entries), LOOP_DEPTH (default 4, hardware-loop nesting) and PC_STEP (default 2, PC increment per instruction).
REQ-002 SHALL have ports: clk input 1 (single clock); rst input 1 (reset is synchronous and active-high).
REQ-003 SHALL have ports: instruction input instruction_t (current instruction); diverge_consensus input 1 (UNL branch condition); stall input 1 (freezes all state).
REQ-004 SHALL have ports: program_counter output pc_reg_t (registered PC); next_program_counter output pc_reg_t (combinational next PC).
REQ-005 SHALL have ports: call_depth output $clog2(CALL_DEPTH+1) (live call entries); loop_depth output $clog2(LOOP_DEPTH+1) (live loop entries); halted output 1; fault output 1; fault_code output fault_code_t.

Function
REQ-006 SHALL implement states RUN, HALTED and FAULT; RUN→HALTED on HALT; RUN→FAULT on stack overflow/underflow; leave HALTED/FAULT only via rst.
REQ-007 SHALL, in RUN with stall=0, update state on every rising clk: program_counter <= next_program_counter.
REQ-008 SHALL, when stall=1, hold PC, both stacks, depths and state unchanged; next_program_counter = program_counter; stall has priority over all opcodes.
REQ-009 SHALL, in HALTED or FAULT, drive next_program_counter = program_counter and ignore instruction.
REQ-010 SHALL decode, in RUN: JUMP → jump_addr; UNL → zero-extended immediate if diverge_consensus=1, else PC+PC_STEP; all other opcodes not named here → PC+PC_STEP.
REQ-011 SHALL, on CALL: push PC+PC_STEP, increment call_depth and go to jump_addr; when call_depth==CALL_DEPTH, instead enter FAULT with CALL_OVF and hold PC.
REQ-012 SHALL, on RET: go to the top entry and decrement call_depth; when call_depth==0, instead enter FAULT with CALL_UDF and hold PC.
REQ-013 SHALL, on LOOP: push {start=PC+PC_STEP, count=immediate}, treating count 0 as 1, and go to PC+PC_STEP; when loop_depth==LOOP_DEPTH, instead enter FAULT with LOOP_OVF.
REQ-014 SHALL, on ENDL: if top count>1, decrement it and go to start; if count==1, pop and go to PC+PC_STEP; when loop_depth==0, instead enter FAULT with LOOP_UDF.
REQ-015 SHALL, on HALT: hold PC at the HALT address and assert halted the cycle after.
REQ-016 SHALL use modulo 2^program_counter_length for PC arithmetic (PC wraps without fault), and store loop counts at immediate_length width.
REQ-017 SHALL keep fault=1 with fault_code latched while in FAULT, and fault_code=NONE otherwise; halted and fault are never both 1.
REQ-018 SHALL apply the stack write and depth change in the same clock edge as the PC update; an overflowing push or underflowing pop leaves stack contents unchanged.

Reset
REQ-019 SHALL, when rst=1 at a clk edge, set program_counter=0, call_depth=0, loop_depth=0, state=RUN, halted=0, fault=0 and fault_code=NONE, regardless of stall or state, including mid-loop or mid-call.
REQ-020 SHALL not reset stack storage contents; entries are unreachable because both depths are 0.

Structure
REQ-021 SHALL add opcodes LOOP, ENDL and HALT, plus fault_code_t {NONE, CALL_OVF, CALL_UDF, LOOP_OVF, LOOP_UDF}, to the isa package; stack-pointer widths derive locally from the parameters.
REQ-022 SHALL instantiate one sub-module lifo_stack (parameters WIDTH and DEPTH; push, pop, full, empty, top, depth) twice: once for calls and once for loop entries.

Verification
REQ-023 Bench SHALL check: reset followed by 3 NOPs -> program_counter 0x00, 0x02, 0x04, 0x06; call_depth stays 0.
REQ-024 Bench SHALL check: CALL 0x40 at 0x10, then RET at 0x40 -> PC 0x40 then 0x12; call_depth goes 1 then 0.
REQ-025 Bench SHALL check: LOOP imm=3 at 0x20, NOP at 0x22, ENDL at 0x24 -> PC sequence 0x22, 0x24, 0x22, 0x24, 0x22, 0x24, 0x26; loop_depth returns to 0.
REQ-026 Bench SHALL check: CALL_DEPTH=4 with 5 nested CALLs -> fault=1, fault_code=CALL_OVF, PC frozen at the fifth CALL address; rst restores PC=0 and fault=0.
REQ-027 Bench SHALL check: RET at depth 0 -> CALL_UDF; ENDL at depth 0 -> LOOP_UDF; HALT at 0x30 -> halted=1 with PC held at 0x30 for 10 cycles.
REQ-028 Bench SHALL check: stall=1 for 3 cycles with CALL presented -> no push and PC held, then push on the first unstalled edge; UNL imm=0x08 with consensus=1 -> PC 0x08, and with consensus=0 -> PC+2.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared ISA types for the sequencer: opcodes, instruction word, PC and fault codes.
package sequencer_pkg;

   localparam int PC_W  = 16;
   localparam int IMM_W = 8;

   typedef logic [PC_W-1:0]  pc_reg_t;
   typedef logic [IMM_W-1:0] imm_t;

   typedef enum logic [3:0] {
      NOP  = 4'd0,
      JUMP = 4'd1,
      CALL = 4'd2,
      RET  = 4'd3,
      UNL  = 4'd4,
      LOOP = 4'd5,
      ENDL = 4'd6,
      HALT = 4'd7
   } opcode_t;

   typedef struct packed {
      opcode_t opcode;
      pc_reg_t jump_addr;
      imm_t    immediate;
   } instruction_t;

   typedef enum logic [2:0] {
      NONE     = 3'd0,
      CALL_OVF = 3'd1,
      CALL_UDF = 3'd2,
      LOOP_OVF = 3'd3,
      LOOP_UDF = 3'd4
   } fault_code_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      FAULT  = 2'd2
   } seq_state_t;

   typedef struct packed {
      pc_reg_t start;
      imm_t    count;
   } loop_ent_t;

endpackage

// File: rtl/sequencer_lifo.sv
// Generic LIFO: push and pop together rewrite the top entry in place.
// Storage is never cleared; only the depth pointer is reset.
module lifo_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           push_dat_i,
   output logic [WIDTH-1:0]           top_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] depth_o
);

   localparam int PW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    depth_q;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    wr_idx;
   logic             replace;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (depth_q == PW'(DEPTH));
   assign empty_o = (depth_q == '0);
   assign depth_o = depth_q;

   assign replace = push_i && pop_i && !empty_o;
   assign do_push = push_i && !pop_i && !full_o;
   assign do_pop  = pop_i && !push_i && !empty_o;

   assign top_idx = AW'(depth_q - PW'(1));
   assign wr_idx  = replace ? top_idx : AW'(depth_q);
   assign top_o   = mem_q[top_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         depth_q <= '0;
      end else if (do_push) begin
         depth_q <= depth_q + PW'(1);
      end else if (do_pop) begin
         depth_q <= depth_q - PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push || replace) begin
         mem_q[wr_idx] <= push_dat_i;
      end
   end

endmodule

// File: rtl/sequencer.sv
// Program sequencer: PC, call stack and hardware-loop stack with halt/fault states.
// Stall freezes everything; HALTED/FAULT are sticky until rst.
module sequencer
   import sequencer_pkg::*;
#(
   parameter int CALL_DEPTH = 32,
   parameter int LOOP_DEPTH = 4,
   parameter int PC_STEP    = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  instruction_t                    instruction,
   input  logic                            diverge_consensus,
   input  logic                            stall,
   output pc_reg_t                         program_counter,
   output pc_reg_t                         next_program_counter,
   output logic [$clog2(CALL_DEPTH+1)-1:0] call_depth,
   output logic [$clog2(LOOP_DEPTH+1)-1:0] loop_depth,
   output logic                            halted,
   output logic                            fault,
   output fault_code_t                     fault_code
);

   localparam int LW = $bits(loop_ent_t);

   pc_reg_t     pc_q, pc_d, pc_inc;
   seq_state_t  state_q, state_d;
   fault_code_t fcode_q, fcode_d;

   logic      call_push, call_pop, call_full, call_empty;
   pc_reg_t   call_top;
   logic      loop_push, loop_pop, loop_full, loop_empty;
   loop_ent_t loop_din, loop_top;
   logic [LW-1:0] loop_top_raw;

   assign pc_inc   = pc_q + PC_W'(PC_STEP);
   assign loop_top = loop_ent_t'(loop_top_raw);

   always_comb begin
      pc_d      = pc_q;
      state_d   = state_q;
      fcode_d   = fcode_q;
      call_push = 1'b0;
      call_pop  = 1'b0;
      loop_push = 1'b0;
      loop_pop  = 1'b0;
      loop_din  = '{start: pc_inc, count: instruction.immediate};

      if (!stall && state_q == RUN) begin
         case (instruction.opcode)
            JUMP: pc_d = instruction.jump_addr;
            UNL:  pc_d = diverge_consensus ? PC_W'(instruction.immediate) : pc_inc;
            CALL: begin
               if (call_full) begin
                  state_d = FAULT;
                  fcode_d = CALL_OVF;
               end else begin
                  call_push = 1'b1;
                  pc_d      = instruction.jump_addr;
               end
            end
            RET: begin
               if (call_empty) begin
                  state_d = FAULT;
                  fcode_d = CALL_UDF;
               end else begin
                  call_pop = 1'b1;
                  pc_d     = call_top;
               end
            end
            LOOP: begin
               if (loop_full) begin
                  state_d = FAULT;
                  fcode_d = LOOP_OVF;
               end else begin
                  loop_push = 1'b1;
                  if (instruction.immediate == '0) loop_din.count = imm_t'(1);
                  pc_d = pc_inc;
               end
            end
            ENDL: begin
               if (loop_empty) begin
                  state_d = FAULT;
                  fcode_d = LOOP_UDF;
               end else if (loop_top.count > imm_t'(1)) begin
                  // push+pop rewrites the top entry with the decremented count
                  loop_push = 1'b1;
                  loop_pop  = 1'b1;
                  loop_din  = '{start: loop_top.start, count: loop_top.count - imm_t'(1)};
                  pc_d      = loop_top.start;
               end else begin
                  loop_pop = 1'b1;
                  pc_d     = pc_inc;
               end
            end
            HALT:    state_d = HALTED;
            default: pc_d = pc_inc;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         state_q <= RUN;
         fcode_q <= NONE;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         fcode_q <= fcode_d;
      end
   end

   lifo_stack #(.WIDTH(PC_W), .DEPTH(CALL_DEPTH)) u_call_stack (
      .clk        (clk),
      .rst        (rst),
      .push_i     (call_push),
      .pop_i      (call_pop),
      .push_dat_i (pc_inc),
      .top_o      (call_top),
      .full_o     (call_full),
      .empty_o    (call_empty),
      .depth_o    (call_depth)
   );

   lifo_stack #(.WIDTH(LW), .DEPTH(LOOP_DEPTH)) u_loop_stack (
      .clk        (clk),
      .rst        (rst),
      .push_i     (loop_push),
      .pop_i      (loop_pop),
      .push_dat_i (loop_din),
      .top_o      (loop_top_raw),
      .full_o     (loop_full),
      .empty_o    (loop_empty),
      .depth_o    (loop_depth)
   );

   assign program_counter      = pc_q;
   assign next_program_counter = pc_d;
   assign halted               = (state_q == HALTED);
   assign fault                = (state_q == FAULT);
   assign fault_code           = (state_q == FAULT) ? fcode_q : NONE;

endmodule

// File: tb/tb_sequencer.sv
// Sequencer bench: directed scenarios plus random instruction streams against a queue-based model.
module tb_sequencer;
   import sequencer_pkg::*;

   localparam int CD = 4;
   localparam int LD = 4;

   logic         clk = 1'b0;
   logic         rst;
   instruction_t instruction;
   logic         diverge_consensus;
   logic         stall;
   pc_reg_t      program_counter;
   pc_reg_t      next_program_counter;
   logic [2:0]   call_depth;
   logic [2:0]   loop_depth;
   logic         halted;
   logic         fault;
   fault_code_t  fault_code;

   sequencer #(.CALL_DEPTH(CD), .LOOP_DEPTH(LD), .PC_STEP(2)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .instruction          (instruction),
      .diverge_consensus    (diverge_consensus),
      .stall                (stall),
      .program_counter      (program_counter),
      .next_program_counter (next_program_counter),
      .call_depth           (call_depth),
      .loop_depth           (loop_depth),
      .halted               (halted),
      .fault                (fault),
      .fault_code           (fault_code)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: PC, stacks as queues, mode 0=run 1=halted 2=fault.
   logic [15:0] m_pc;
   logic [15:0] m_nxt;
   logic [15:0] m_cs[$];
   logic [15:0] m_ls_start[$];
   int          m_ls_cnt[$];
   int          m_mode;
   fault_code_t m_fc;

   task automatic model_step(input opcode_t op, input logic [15:0] ja, input logic [7:0] imm,
                             input logic cons, input logic stl, input logic r);
      int top;
      if (r) begin
         m_pc = 16'h0; m_nxt = 16'h0; m_cs.delete(); m_ls_start.delete(); m_ls_cnt.delete();
         m_mode = 0; m_fc = NONE;
         return;
      end
      m_nxt = m_pc;
      if (stl || m_mode != 0) return;
      case (op)
         JUMP: m_nxt = ja;
         UNL:  m_nxt = cons ? {8'h00, imm} : m_pc + 16'd2;
         CALL: if (m_cs.size() == CD) begin m_mode = 2; m_fc = CALL_OVF; end
               else begin m_cs.push_back(m_pc + 16'd2); m_nxt = ja; end
         RET:  if (m_cs.size() == 0) begin m_mode = 2; m_fc = CALL_UDF; end
               else m_nxt = m_cs.pop_back();
         LOOP: if (m_ls_cnt.size() == LD) begin m_mode = 2; m_fc = LOOP_OVF; end
               else begin
                  m_ls_start.push_back(m_pc + 16'd2);
                  m_ls_cnt.push_back((imm == 8'd0) ? 1 : int'(imm));
                  m_nxt = m_pc + 16'd2;
               end
         ENDL: if (m_ls_cnt.size() == 0) begin m_mode = 2; m_fc = LOOP_UDF; end
               else begin
                  top = m_ls_cnt.size() - 1;
                  if (m_ls_cnt[top] > 1) begin
                     m_ls_cnt[top] = m_ls_cnt[top] - 1;
                     m_nxt = m_ls_start[top];
                  end else begin
                     void'(m_ls_cnt.pop_back());
                     void'(m_ls_start.pop_back());
                     m_nxt = m_pc + 16'd2;
                  end
               end
         HALT: m_mode = 1;
         default: m_nxt = m_pc + 16'd2;
      endcase
   endtask

   task automatic step(input opcode_t op, input logic [15:0] ja, input logic [7:0] imm,
                       input logic cons, input logic stl, input logic r);
      instruction.opcode    = op;
      instruction.jump_addr = ja;
      instruction.immediate = imm;
      diverge_consensus     = cons;
      stall                 = stl;
      rst                   = r;
      #1;
      model_step(op, ja, imm, cons, stl, r);
      if (!r) chk("next_pc", 32'(next_program_counter), 32'(m_nxt));
      m_pc = m_nxt;
      @(posedge clk);
      #1;
      chk("pc",         32'(program_counter), 32'(m_pc));
      chk("call_depth", 32'(call_depth),      32'(m_cs.size()));
      chk("loop_depth", 32'(loop_depth),      32'(m_ls_cnt.size()));
      chk("halted",     32'(halted),          32'(m_mode == 1));
      chk("fault",      32'(fault),           32'(m_mode == 2));
      chk("fault_code", 32'(fault_code),      32'((m_mode == 2) ? m_fc : NONE));
   endtask

   task automatic do_rst();
      step(NOP, 16'h0, 8'h0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic op_s(input opcode_t op, input logic [15:0] ja, input logic [7:0] imm);
      step(op, ja, imm, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [15:0] exp_loop [6];
      logic [15:0] ja;
      logic [7:0]  imm;
      opcode_t     op;
      int          sel;

      exp_loop[0] = 16'h24; exp_loop[1] = 16'h22; exp_loop[2] = 16'h24;
      exp_loop[3] = 16'h22; exp_loop[4] = 16'h24; exp_loop[5] = 16'h26;
      m_pc = 16'h0; m_mode = 0; m_fc = NONE;

      // reset under stall, then NOPs
      do_rst();
      step(CALL, 16'h80, 8'h0, 1'b0, 1'b1, 1'b1);
      chk("rst_pc", 32'(program_counter), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      for (int i = 1; i <= 3; i++) begin
         op_s(NOP, 16'h0, 8'h0);
         chk("nop_pc", 32'(program_counter), 32'(2 * i));
         chk("nop_cdepth", 32'(call_depth), 32'h0);
      end

      // call / return
      op_s(JUMP, 16'h10, 8'h0);
      op_s(CALL, 16'h40, 8'h0);
      chk("call_pc", 32'(program_counter), 32'h40);
      chk("call_depth1", 32'(call_depth), 32'h1);
      op_s(RET, 16'h0, 8'h0);
      chk("ret_pc", 32'(program_counter), 32'h12);
      chk("ret_depth0", 32'(call_depth), 32'h0);

      // hardware loop, count 3
      op_s(JUMP, 16'h20, 8'h0);
      op_s(LOOP, 16'h0, 8'd3);
      chk("loop_pc", 32'(program_counter), 32'h22);
      for (int i = 0; i < 6; i++) begin
         op_s((m_pc == 16'h22) ? NOP : ENDL, 16'h0, 8'h0);
         chk("loop_seq", 32'(program_counter), 32'(exp_loop[i]));
      end
      chk("loop_depth0", 32'(loop_depth), 32'h0);

      // call overflow at depth 4
      do_rst();
      for (int i = 1; i <= 5; i++) op_s(CALL, 16'(i * 16'h100), 8'h0);
      chk("ovf_fault", 32'(fault), 32'h1);
      chk("ovf_code", 32'(fault_code), 32'(CALL_OVF));
      chk("ovf_pc", 32'(program_counter), 32'h400);
      op_s(JUMP, 16'h1234, 8'h0);
      chk("ovf_sticky_pc", 32'(program_counter), 32'h400);
      do_rst();
      chk("ovf_rst_pc", 32'(program_counter), 32'h0);
      chk("ovf_rst_fault", 32'(fault), 32'h0);

      // underflows
      op_s(RET, 16'h0, 8'h0);
      chk("call_udf", 32'(fault_code), 32'(CALL_UDF));
      do_rst();
      op_s(ENDL, 16'h0, 8'h0);
      chk("loop_udf", 32'(fault_code), 32'(LOOP_UDF));
      do_rst();

      // halt
      op_s(JUMP, 16'h30, 8'h0);
      op_s(HALT, 16'h0, 8'h0);
      for (int i = 0; i < 10; i++) begin
         op_s(JUMP, 16'h77, 8'h0);
         chk("halt_pc", 32'(program_counter), 32'h30);
         chk("halted", 32'(halted), 32'h1);
         chk("halt_nofault", 32'(fault), 32'h0);
      end
      do_rst();

      // stall with CALL presented
      op_s(JUMP, 16'h60, 8'h0);
      for (int i = 0; i < 3; i++) begin
         step(CALL, 16'h50, 8'h0, 1'b0, 1'b1, 1'b0);
         chk("stall_pc", 32'(program_counter), 32'h60);
         chk("stall_depth", 32'(call_depth), 32'h0);
      end
      op_s(CALL, 16'h50, 8'h0);
      chk("unstall_pc", 32'(program_counter), 32'h50);
      chk("unstall_depth", 32'(call_depth), 32'h1);
      op_s(RET, 16'h0, 8'h0);
      chk("stall_ret_pc", 32'(program_counter), 32'h62);

      // UNL
      step(UNL, 16'h0, 8'h08, 1'b1, 1'b0, 1'b0);
      chk("unl_taken", 32'(program_counter), 32'h08);
      step(UNL, 16'h0, 8'h08, 1'b0, 1'b0, 1'b0);
      chk("unl_not_taken", 32'(program_counter), 32'h0A);

      // PC wrap
      op_s(JUMP, 16'hFFFE, 8'h0);
      op_s(NOP, 16'h0, 8'h0);
      chk("pc_wrap", 32'(program_counter), 32'h0);

      // random streams
      for (int n = 0; n < 3000; n++) begin
         sel = $urandom_range(0, 15);
         case (sel)
            4:       op = JUMP;
            5, 6:    op = CALL;
            7, 8:    op = RET;
            9:       op = UNL;
            10, 11:  op = LOOP;
            12, 13:  op = ENDL;
            14:      op = HALT;
            default: op = NOP;
         endcase
         ja  = 16'($urandom);
         imm = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         step(op, ja, imm, 1'($urandom), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 23) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule
